// File: rtl/fpu_pkg.sv
// Shared fp16 field layout and result-class encoding for the FPU blocks.
package fpu_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MANT_MSB = 9;
  localparam logic [4:0] EXP_ALL_ONES = 5'h1F;

  // Bit positions inside the class vector {nan, inf, zero, subnormal, sign}
  localparam int CLS_NAN  = 4;
  localparam int CLS_INF  = 3;
  localparam int CLS_ZERO = 2;
  localparam int CLS_SUB  = 1;
  localparam int CLS_SIGN = 0;
  localparam int CLS_W    = 5;

  typedef logic [CLS_W-1:0] fp16_class_t;

endpackage

// File: rtl/fpu_result_fifo_if.sv
// Handshake bundle between the fp16 adder / issue logic, the result FIFO and the consumer.
interface fpu_result_fifo_if
  import fpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              issue_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic              can_issue;
    logic [DATA_W-1:0] out_data;
    fp16_class_t       out_class;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              clr_overflow;

    // master: the surrounding logic (issue, adder, consumer); slave: the FIFO
    modport master (
        output issue_valid, res_data, res_valid, out_ready, clr_overflow,
        input  can_issue, out_data, out_class, out_valid, count, overflow
    );

    modport slave (
        input  issue_valid, res_data, res_valid, out_ready, clr_overflow,
        output can_issue, out_data, out_class, out_valid, count, overflow
    );

endinterface

// File: rtl/fp16_classify.sv
// Combinational IEEE-754 half-precision classifier producing {nan, inf, zero, subnormal, sign}.
module fp16_classify
  import fpu_pkg::*;
(
    input  logic [15:0] data,
    output fp16_class_t cls
);

    logic [4:0] exp_f;
    logic [9:0] mant;

    assign exp_f = data[EXP_MSB:EXP_LSB];
    assign mant  = data[MANT_MSB:0];

    always_comb begin
        cls           = '0;
        cls[CLS_NAN]  = (exp_f == EXP_ALL_ONES) && (mant != '0);
        cls[CLS_INF]  = (exp_f == EXP_ALL_ONES) && (mant == '0);
        cls[CLS_ZERO] = (exp_f == '0) && (mant == '0);
        cls[CLS_SUB]  = (exp_f == '0) && (mant != '0);
        cls[CLS_SIGN] = data[SIGN_BIT];
    end

endmodule

// File: rtl/fpu_result_fifo.sv
// Credit-controlled result FIFO behind the fp16 adder; FPU_RESULT_CLASS_EN adds a stored
// per-entry class vector, otherwise out_class is tied to zero.
module fpu_result_fifo
  import fpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
)(
    input logic              clk,
    input logic              rst_n,
    fpu_result_fifo_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
`ifdef FPU_RESULT_CLASS_EN
    localparam int ENTRY_W = DATA_W + CLS_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      inflight;
    logic [CW:0]        credit_sum;
    logic               overflow;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic               drop;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign pop   = !empty && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the beat.
    assign push  = bus.res_valid && (!full || pop);
    assign drop  = bus.res_valid && full && !pop;

`ifdef FPU_RESULT_CLASS_EN
    fp16_class_t res_class;

    fp16_classify u_classify (
        .data (bus.res_data),
        .cls  (res_class)
    );

    assign wr_entry      = {res_class, bus.res_data};
    assign bus.out_class = empty ? '0 : head[ENTRY_W-1:DATA_W];
`else
    assign wr_entry      = bus.res_data;
    assign bus.out_class = '0;
`endif

    assign head          = mem[rd_ptr];
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : head[DATA_W-1:0];
    assign bus.count     = count;
    assign bus.overflow  = overflow;

    // Results already in the adder count against the free slots.
    assign credit_sum    = {1'b0, count} + {1'b0, inflight};
    assign bus.can_issue = (credit_sum < {1'b0, DEPTH_C});

    // Storage holds no control state and is left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                overflow <= 1'b0;
            end

            // Saturate both ways: stale results after a reset must not wrap the credit.
            if (bus.issue_valid && !bus.res_valid) begin
                if (inflight != DEPTH_C) begin
                    inflight <= inflight + 1'b1;
                end
            end else if (bus.res_valid && !bus.issue_valid) begin
                if (inflight != '0) begin
                    inflight <= inflight - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_fifo.sv
// Scoreboard bench for fpu_result_fifo; class expectations follow FPU_RESULT_CLASS_EN.
module tb_fpu_result_fifo;

`ifdef FPU_RESULT_CLASS_EN
    localparam bit CLS_ON = 1'b1;
`else
    localparam bit CLS_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [4:0]  cls;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    exp_t exp_q[$];

    logic [15:0] vec_a   [4]  = '{16'h3C00, 16'h7C00, 16'h7E01, 16'h0001};
    logic [4:0]  cls_a   [4]  = '{5'b00000, 5'b01000, 5'b10000, 5'b00010};
    logic [15:0] vec_d   [10] = '{16'h0000, 16'h8001, 16'h7C01, 16'hFFFF, 16'h3555,
                                  16'h0400, 16'h03FF, 16'h8000, 16'h7BFF, 16'hFC01};
    logic [4:0]  cls_d   [10] = '{5'b00100, 5'b00011, 5'b10000, 5'b10001, 5'b00000,
                                  5'b00000, 5'b00010, 5'b00101, 5'b00000, 5'b10001};

    fpu_result_fifo_if #(.DEPTH(4), .DATA_W(16)) bus ();

    fpu_result_fifo #(.DEPTH(4), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [4:0] exp_cls(input logic [4:0] c);
        return CLS_ON ? c : 5'b0;
    endfunction

    task automatic expect_push(input logic [15:0] d, input logic [4:0] c);
        exp_t e;
        e.data = d;
        e.cls  = exp_cls(c);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head is compared against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL pop_unexpected: got %h, required no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", 32'(bus.out_data), 32'(e.data));
                    check("pop_class", 32'(bus.out_class), 32'(e.cls));
                end
            end
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b1;
        bus.issue_valid = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        bus.out_ready = 1'b0;
        bus.clr_overflow = 1'b0;

        // Asynchronous reset asserted mid-cycle
        #13 rst_n = 1'b0;
        #1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_class", 32'(bus.out_class), 0);
        check("rst_overflow", 32'(bus.overflow), 0);
        check("rst_can_issue", 32'(bus.can_issue), 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Four issues consume all credit
        for (int i = 0; i < 4; i++) begin
            check("issue_can_issue", 32'(bus.can_issue), 1);
            bus.issue_valid = 1'b1;
            step();
        end
        bus.issue_valid = 1'b0;
        check("credit_exhausted", 32'(bus.can_issue), 0);

        for (int i = 0; i < 4; i++) begin
            bus.res_valid = 1'b1;
            bus.res_data = vec_a[i];
            expect_push(vec_a[i], cls_a[i]);
            if (i == 0) check("no_fall_through", 32'(bus.out_valid), 0);
            step();
            if (i == 0) check("first_valid", 32'(bus.out_valid), 1);
        end
        bus.res_valid = 1'b0;
        check("full_count", 32'(bus.count), 4);
        check("full_can_issue", 32'(bus.can_issue), 0);
        check("head_data", 32'(bus.out_data), 32'h3C00);
        check("head_class", 32'(bus.out_class), 32'(exp_cls(5'b00000)));

        // Full FIFO: push and pop together
        bus.res_valid = 1'b1;
        bus.res_data = 16'hFC00;
        bus.out_ready = 1'b1;
        expect_push(16'hFC00, 5'b01001);
        step();
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("pushpop_count", 32'(bus.count), 4);
        check("pushpop_overflow", 32'(bus.overflow), 0);
        check("next_head_data", 32'(bus.out_data), 32'h7C00);
        check("next_head_class", 32'(bus.out_class), 32'(exp_cls(5'b01000)));

        // Full FIFO without pop: drop, then set-wins, then clear
        bus.res_valid = 1'b1;
        bus.res_data = 16'h8000;
        step();
        check("drop_overflow", 32'(bus.overflow), 1);
        check("drop_count", 32'(bus.count), 4);
        check("drop_head", 32'(bus.out_data), 32'h7C00);
        bus.clr_overflow = 1'b1;
        step();
        check("set_wins", 32'(bus.overflow), 1);
        bus.res_valid = 1'b0;
        step();
        bus.clr_overflow = 1'b0;
        check("clr_overflow", 32'(bus.overflow), 0);

        // Drain, then pop attempt on an empty FIFO
        bus.out_ready = 1'b1;
        repeat (4) step();
        check("drained_count", 32'(bus.count), 0);
        check("drained_valid", 32'(bus.out_valid), 0);
        check("drained_data", 32'(bus.out_data), 0);
        check("drained_class", 32'(bus.out_class), 0);
        step();
        check("pop_empty_count", 32'(bus.count), 0);

        // Issue and result every cycle: credit stays balanced
        for (int i = 0; i < 10; i++) begin
            bus.issue_valid = 1'b1;
            bus.res_valid = 1'b1;
            bus.res_data = vec_d[i];
            expect_push(vec_d[i], cls_d[i]);
            check("stream_can_issue", 32'(bus.can_issue), 1);
            step();
            check("stream_count", 32'(bus.count), 1);
            check("stream_overflow", 32'(bus.overflow), 0);
        end
        bus.issue_valid = 1'b0;
        bus.res_valid = 1'b0;
        step();
        check("stream_end_count", 32'(bus.count), 0);
        check("stream_end_can_issue", 32'(bus.can_issue), 1);

        // Reset in the middle of traffic
        bus.out_ready = 1'b0;
        bus.issue_valid = 1'b1;
        repeat (2) step();
        bus.issue_valid = 1'b0;
        bus.res_valid = 1'b1;
        bus.res_data = 16'h4000;
        step();
        bus.res_data = 16'hC000;
        step();
        bus.res_valid = 1'b0;
        check("pre_reset_count", 32'(bus.count), 2);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_can_issue", 32'(bus.can_issue), 1);
        #3 rst_n = 1'b1;
        step();

        // Stale adder result after reset: stored, credit saturates at zero
        bus.res_valid = 1'b1;
        bus.res_data = 16'h4000;
        expect_push(16'h4000, 5'b00000);
        step();
        bus.res_valid = 1'b0;
        check("stale_count", 32'(bus.count), 1);
        check("stale_can_issue", 32'(bus.can_issue), 1);
        bus.issue_valid = 1'b1;
        repeat (3) step();
        bus.issue_valid = 1'b0;
        check("credit_with_entry", 32'(bus.can_issue), 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("credit_after_pop", 32'(bus.can_issue), 1);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_result_fifo.md
Name: fpu_result_fifo

Overview:
- Downstream stage of the pipelined fp16 adder. The adder has no backpressure, so this block captures every `result`/`valid_out` beat in a small FIFO.
- Presents buffered results to the TinyQV-side consumer over a valid/ready handshake.
- Issues a credit signal (`can_issue`) so the issue logic never has more results in flight than free FIFO slots.
- Optionally tags each result with an IEEE-754 half-precision class vector.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, 16, result width; fixed to fp16 layout (sign[15], exp[14:10], mant[9:0]).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- issue_valid  input  1  pulse when an operand pair enters the adder (same signal as the adder's valid_in)
- res_data  input  16  adder result
- res_valid  input  1  adder valid_out
- can_issue  output  1  high when one more operation may be issued
- out_data  output  16  FIFO head result
- out_class  output  5  {nan, inf, zero, subnormal, sign} of head entry
- out_valid  output  1  head entry present
- out_ready  input  1  consumer accepts head
- count  output  $clog2(DEPTH)+1  occupied entries
- overflow  output  1  sticky: a result was dropped
- clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, rst_n low): all of the following are 0 immediately:
  - wr_ptr, rd_ptr, count, inflight counter, overflow
  - out_valid, out_data, out_class
  - Storage array is not reset.
- Push:
  - `res_valid` high pushes `res_data` (and its class) into the FIFO on the rising edge.
  - First-word fall-through is not used. An entry pushed into an empty FIFO at edge N shows `out_valid=1` from N+1.
- Pop:
  - `out_valid & out_ready` pops the head at the edge.
  - `out_data`/`out_class` show the next entry in the following cycle.
  - `out_ready` with empty FIFO: no effect.
- While `out_valid=0`, `out_data` and `out_class` are driven 0.
- Push and pop in the same cycle:
  - `count` is unchanged.
  - When full, the push is accepted because the pop frees a slot. No overflow.
- Push when full with no pop: result dropped, `overflow` set (sticky), pointers and count unchanged.
- Overflow flag: `clr_overflow` clears it. If a drop and `clr_overflow` occur in the same cycle, set wins.
- Pointers: wrap modulo DEPTH. `count` ranges 0..DEPTH.
- Credit (inflight counter, width $clog2(DEPTH)+1):
  - +1 on `issue_valid`, −1 on `res_valid`; both in the same cycle: unchanged.
  - Saturates at 0 (spurious `res_valid`) and at DEPTH.
- `can_issue` is combinational: (count + inflight) < DEPTH.
  - Protocol: upstream asserts `issue_valid` only when `can_issue=1`.
  - A violation is still counted, may overflow, and is recorded via the overflow flag.
- Classification:
  - nan = exp==5'h1F & mant!=0
  - inf = exp==5'h1F & mant==0
  - zero = exp==0 & mant==0
  - subnormal = exp==0 & mant!=0
  - sign = bit 15 (valid for every class, including NaN)
- Mid-operation reset: discards all entries and in-flight credit. Results still in the adder pipeline after reset are pushed normally, and the inflight counter saturates at 0.

Optional Feature:
- Macro: FPU_RESULT_CLASS_EN.
- Defined: class vector computed at push and stored alongside each entry (storage width 21 bits); `out_class` as above.
- Undefined: no class storage or logic; `out_class` tied to 5'b0; all other behaviour identical.

Decomposition:
- Shared package `fpu_pkg`:
  - fp16 field constants: SIGN_BIT=15, EXP_MSB=14, EXP_LSB=10, MANT_MSB=9, EXP_ALL_ONES=5'h1F.
  - Class bit indices: CLS_NAN=4, CLS_INF=3, CLS_ZERO=2, CLS_SUB=1, CLS_SIGN=0.
  - Class vector typedef, reusable by other FPU blocks.
- Sub-module: `fp16_classify`, purely combinational, 16-bit in, 5-bit class out. Instantiated only under FPU_RESULT_CLASS_EN.

Test Plan:
- Reset with rst_n low mid-cycle → all outputs 0 asynchronously, can_issue=1.
- Issue 4 ops; push 3C00, 7C00, 7E01, 0001 with out_ready=0:
  - count=4, can_issue=0.
  - Head 3C00 with class 00000; successive pops yield classes 01000, 10000, 00010.
- Full FIFO, push FC00 with out_ready=1 same cycle → accepted, count stays 4, overflow=0, next heads end with FC00 (class 01001).
- Full FIFO, push 8000 with out_ready=0 → dropped, overflow=1. Then clr_overflow → overflow=0.
- issue_valid and res_valid together every cycle for 10 cycles with out_ready=1 → inflight constant, can_issue never drops, no overflow.
- Build without FPU_RESULT_CLASS_EN, push 7C00 → out_class=0, out_data=7C00.
